// File: rtl/gnrl_skid_buf.sv
// Two-entry elastic buffer with a valid/ready handshake on both sides; i_rdy comes from registered state only.
// Optional combinational flow-through when empty: define GNRL_SKID_BUF_BYPASS_EN.
//
// state | meaning
// EMPTY | no word stored; o_vld low unless bypassing
// ONE   | one word stored, head at slot[rp]
// FULL  | two words stored; i_rdy low

module gnrl_skid_buf #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat,
   output logic [1:0]    o_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state;
   logic          rdy_q;
   logic          vld_q;
   logic          wp;
   logic          rp;
   logic [DW-1:0] slot [2];

   logic          in_hs;
   logic          out_hs;
   logic          push;
   logic          pop;

   assign in_hs  = i_vld & rdy_q;
   assign out_hs = o_vld & o_rdy;

`ifdef GNRL_SKID_BUF_BYPASS_EN
   logic byp;

   // Flow-through only when nothing is queued ahead of the incoming word.
   assign byp   = (state == EMPTY) & o_rdy;
   assign o_vld = vld_q | (byp & i_vld);
   assign o_dat = byp ? i_dat : slot[rp];
   assign push  = in_hs & ~byp;
   assign pop   = out_hs & ~byp;
`else
   assign o_vld = vld_q;
   assign o_dat = slot[rp];
   assign push  = in_hs;
   assign pop   = out_hs;
`endif

   assign i_rdy = rdy_q;
   assign o_cnt = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         rdy_q   <= 1'b1;
         vld_q   <= 1'b0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         slot[0] <= '0;
         slot[1] <= '0;
      end else begin
         if (push) begin
            slot[wp] <= i_dat;
            wp       <= ~wp;
         end
         if (pop) begin
            rp <= ~rp;
         end
         // rdy_q/vld_q are kept as flops mirroring the next state so both handshake outputs are registered.
         case (state)
            EMPTY: begin
               if (push) begin
                  state <= ONE;
                  vld_q <= 1'b1;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state <= FULL;
                  rdy_q <= 1'b0;
               end else if (pop && !push) begin
                  state <= EMPTY;
                  vld_q <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state <= ONE;
                  rdy_q <= 1'b1;
               end
            end
            default: begin
               state <= EMPTY;
               rdy_q <= 1'b1;
               vld_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Directed bench for gnrl_skid_buf: reset, streaming, back-pressure, push/pop overlap, pointer wrap, bypass.
// Expectations follow GNRL_SKID_BUF_BYPASS_EN when it is defined for the build.

module tb_gnrl_skid_buf;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_vld;
   logic          i_rdy;
   logic [DW-1:0] i_dat;
   logic          o_vld;
   logic          o_rdy;
   logic [DW-1:0] o_dat;
   logic [1:0]    o_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   gnrl_skid_buf #(.DW(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .i_vld (i_vld),
      .i_rdy (i_rdy),
      .i_dat (i_dat),
      .o_vld (o_vld),
      .o_rdy (o_rdy),
      .o_dat (o_dat),
      .o_cnt (o_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
      i_vld = v;
      i_dat = d;
      o_rdy = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [1:0] c, input logic r);
      chk({tag, "_vld"}, {31'b0, o_vld}, {31'b0, v});
      if (v) chk({tag, "_dat"}, {24'b0, o_dat}, {24'b0, d});
      chk({tag, "_cnt"}, {30'b0, o_cnt}, {30'b0, c});
      chk({tag, "_rdy"}, {31'b0, i_rdy}, {31'b0, r});
   endtask

   initial begin
      int nxt;
      int nrx;
      int cyc;

      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      #1;
      chk_out("rst0", 1'b0, 8'h00, 2'd0, 1'b1);
      chk("rst0_odat", {24'b0, o_dat}, 32'h0);
      #11;
      rst = 1'b0;
      tick();

      // streaming with o_rdy held high
`ifdef GNRL_SKID_BUF_BYPASS_EN
      drive(1'b1, 8'h11, 1'b1); @(negedge clk); chk_out("str1", 1'b1, 8'h11, 2'd0, 1'b1); tick();
      drive(1'b1, 8'h22, 1'b1); @(negedge clk); chk_out("str2", 1'b1, 8'h22, 2'd0, 1'b1); tick();
      drive(1'b1, 8'h33, 1'b1); @(negedge clk); chk_out("str3", 1'b1, 8'h33, 2'd0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("str4", 1'b0, 8'h00, 2'd0, 1'b1); tick();
`else
      drive(1'b1, 8'h11, 1'b1); @(negedge clk); chk_out("str1", 1'b0, 8'h00, 2'd0, 1'b1); tick();
      drive(1'b1, 8'h22, 1'b1); @(negedge clk); chk_out("str2", 1'b1, 8'h11, 2'd1, 1'b1); tick();
      drive(1'b1, 8'h33, 1'b1); @(negedge clk); chk_out("str3", 1'b1, 8'h22, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("str4", 1'b1, 8'h33, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("str5", 1'b0, 8'h00, 2'd0, 1'b1); tick();
`endif

      // back-pressure fill, rejected third word, then drain
      drive(1'b1, 8'hA5, 1'b0); @(negedge clk); chk_out("bp1", 1'b0, 8'h00, 2'd0, 1'b1); tick();
      drive(1'b1, 8'h5A, 1'b0); @(negedge clk); chk_out("bp2", 1'b1, 8'hA5, 2'd1, 1'b1); tick();
      drive(1'b1, 8'hFF, 1'b0); @(negedge clk); chk_out("bp3", 1'b1, 8'hA5, 2'd2, 1'b0); tick();
      drive(1'b1, 8'hFF, 1'b0); @(negedge clk); chk_out("bp4", 1'b1, 8'hA5, 2'd2, 1'b0); tick();
      drive(1'b1, 8'hFF, 1'b1); @(negedge clk); chk_out("bp5", 1'b1, 8'hA5, 2'd2, 1'b0); tick();
      drive(1'b1, 8'hFF, 1'b1); @(negedge clk); chk_out("bp6", 1'b1, 8'h5A, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("bp7", 1'b1, 8'hFF, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0); @(negedge clk); chk_out("bp8", 1'b0, 8'h00, 2'd0, 1'b1); tick();

      // simultaneous push and pop at count 1
      drive(1'b1, 8'h01, 1'b0); tick();
      drive(1'b1, 8'h02, 1'b1); @(negedge clk); chk_out("pp1", 1'b1, 8'h01, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("pp2", 1'b1, 8'h02, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0); @(negedge clk); chk_out("pp3", 1'b0, 8'h00, 2'd0, 1'b1); tick();

      // flow-through on an empty buffer with o_rdy high
`ifdef GNRL_SKID_BUF_BYPASS_EN
      drive(1'b1, 8'hC3, 1'b1); @(negedge clk); chk_out("byp1", 1'b1, 8'hC3, 2'd0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("byp2", 1'b0, 8'h00, 2'd0, 1'b1); tick();
`else
      drive(1'b1, 8'hC3, 1'b1); @(negedge clk); chk_out("byp1", 1'b0, 8'h00, 2'd0, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b1); @(negedge clk); chk_out("byp2", 1'b1, 8'hC3, 2'd1, 1'b1); tick();
      drive(1'b0, 8'h00, 1'b0); @(negedge clk); chk_out("byp3", 1'b0, 8'h00, 2'd0, 1'b1); tick();
`endif

      // pointer wrap: values 0..5 through random stalls, checked in order
      nxt = 0;
      nrx = 0;
      cyc = 0;
      while (nrx < 6 && cyc < 80) begin
         drive(nxt < 6, nxt[DW-1:0], (cyc >= 30) ? 1'b1 : 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (o_vld && o_rdy) begin
            chk("wrap_dat", {24'b0, o_dat}, nrx);
            nrx++;
         end
         if (i_vld && i_rdy) nxt++;
         tick();
         cyc++;
      end
      chk("wrap_count", nrx, 6);
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk("wrap_empty", {30'b0, o_cnt}, 32'd0);
      tick();

      // asynchronous reset while full
      drive(1'b1, 8'h77, 1'b0); tick();
      drive(1'b1, 8'h88, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0);
      @(negedge clk);
      chk_out("rfull", 1'b1, 8'h77, 2'd2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst1", 1'b0, 8'h00, 2'd0, 1'b1);
      chk("rst1_odat", {24'b0, o_dat}, 32'h0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'h3C, 1'b0); tick();
      drive(1'b0, 8'h00, 1'b0); @(negedge clk); chk_out("rpost", 1'b1, 8'h3C, 2'd1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
